// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Chunk sizing lives here so the top and any wrapper agree on it.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/full_adder_chunk.sv
// Combinational W-bit ripple-carry adder; exposes the carry into the MSB
// so the last stage can form signed overflow.
module full_adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/pipelined_adder_n.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is cut into STAGES
// registered chunks, with operand/result skew registers and a global stall.
module pipelined_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    op_e              op;
    logic             advance;
    logic [STAGES:0]  vld_pipe;
    stage_t           st [STAGES];

    assign op          = op_e'(sub);
    assign vld_pipe[0] = in_valid;
    assign advance     = !(out_valid && !out_ready);
    assign in_ready    = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] ain, bin, sin, snext;
        logic             cink;
        logic [CHUNK-1:0] s;
        logic             co, cm;
        logic             vld_q;
        stage_t           q;
        logic             unused_bits;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1; cin flips into a borrow.
            assign ain  = a;
            assign bin  = b ^ {WIDTH{op == OP_SUB}};
            assign cink = cin ^ (op == OP_SUB);
            assign sin  = '0;
        end else begin : g_rest
            assign ain  = st[k-1].a;
            assign bin  = st[k-1].b;
            assign cink = st[k-1].carry;
            assign sin  = st[k-1].sum;
        end

        full_adder_chunk #(.W(CHUNK)) u_chunk (
            .a    (ain[k*CHUNK +: CHUNK]),
            .b    (bin[k*CHUNK +: CHUNK]),
            .cin  (cink),
            .sum  (s),
            .cout (co),
            .cmsb (cm)
        );

        always_comb begin
            snext = sin;
            snext[k*CHUNK +: CHUNK] = s;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                q     <= '0;
            end else if (advance) begin
                vld_q   <= vld_pipe[k];
                q.carry <= co;
                q.sum   <= snext;
                q.a     <= ain;
                q.b     <= bin;
            end
        end

        assign vld_pipe[k+1] = vld_q;
        assign st[k]         = q;

        if (k == STAGES - 1) begin : g_last
            logic ovf_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       ovf_q <= 1'b0;
                else if (advance) ovf_q <= cm ^ co;
            end
            assign ovf         = ovf_q;
            assign unused_bits = ^{q.a, q.b};
        end else begin : g_mid
            assign unused_bits = cm;
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = st[STAGES-1].sum;
    assign cout      = st[STAGES-1].carry;

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Directed bench for pipelined_adder_n: 8/2 main instance, plus 8/1 and 32/4.
module tb_pipelined_adder_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 8-bit, 2-stage instance
    logic       iv, ir, ov, ordy, ci, sb, co, of;
    logic [7:0] ia, ib, sm;
    // 8-bit, 1-stage instance
    logic       iv1, ir1, ov1, ordy1, ci1, sb1, co1, of1;
    logic [7:0] ia1, ib1, sm1;
    // 32-bit, 4-stage instance
    logic        iv4, ir4, ov4, ordy4, ci4, sb4, co4, of4;
    logic [31:0] ia4, ib4, sm4;

    pipelined_adder_n #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(ia), .b(ib),
        .cin(ci), .sub(sb), .out_valid(ov), .out_ready(ordy), .sum(sm), .cout(co), .ovf(of));

    pipelined_adder_n #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(ia1), .b(ib1),
        .cin(ci1), .sub(sb1), .out_valid(ov1), .out_ready(ordy1), .sum(sm1), .cout(co1), .ovf(of1));

    pipelined_adder_n #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(ia4), .b(ib4),
        .cin(ci4), .sub(sb4), .out_valid(ov4), .out_ready(ordy4), .sum(sm4), .cout(co4), .ovf(of4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors for the 8/2 instance: a, b, cin, sub -> sum, cout, ovf
    logic [7:0] va [7] = '{8'h03, 8'h07, 8'hFF, 8'h7F, 8'h01, 8'h05, 8'h80};
    logic [7:0] vb [7] = '{8'h05, 8'h08, 8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
    logic       vc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       vs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [7] = '{8'h08, 8'h0F, 8'h00, 8'h80, 8'h03, 8'hFE, 8'h7F};
    logic       ec [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       eo [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    logic [31:0] wa [4] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'h0000FFFF};
    logic [31:0] wb [4] = '{32'h00000001, 32'h00000001, 32'h00000679, 32'h00000001};
    logic        wc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        ws [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ws_e [4] = '{32'h00000000, 32'h80000000, 32'h12344FFE, 32'h00010000};
    logic        wc_e [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        wo_e [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        iv = 0; ia = 0; ib = 0; ci = 0; sb = 0; ordy = 1;
        iv1 = 0; ia1 = 0; ib1 = 0; ci1 = 0; sb1 = 0; ordy1 = 1;
        iv4 = 0; ia4 = 0; ib4 = 0; ci4 = 0; sb4 = 0; ordy4 = 1;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_sum", 32'(sm), 32'd0);
        chk("rst_cout", 32'(co), 32'd0);
        chk("rst_ovf", 32'(of), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(ir), 32'd1);

        // Back-to-back directed beats, no backpressure; result i appears one tick after beat i+1 accepted
        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                iv = 1; ia = va[i]; ib = vb[i]; ci = vc[i]; sb = vs[i];
            end else begin
                iv = 0;
            end
            tick();
            if (i == 0) chk("lat_not_early", 32'(ov), 32'd0);
            else begin
                chk($sformatf("vec%0d_valid", i-1), 32'(ov), 32'd1);
                chk($sformatf("vec%0d_sum", i-1), 32'(sm), 32'(es[i-1]));
                chk($sformatf("vec%0d_cout", i-1), 32'(co), 32'(ec[i-1]));
                chk($sformatf("vec%0d_ovf", i-1), 32'(of), 32'(eo[i-1]));
            end
        end
        tick();
        chk("drain_empty", 32'(ov), 32'd0);

        // Throughput with out_ready low for cycles 4..6
        begin
            int nsent = 0;
            int ngot = 0;
            logic [7:0] held = 8'h00;
            for (int cyc = 0; cyc < 24; cyc++) begin
                iv = (nsent < 8); ia = 8'(nsent); ib = 8'(nsent * 3); ci = nsent[0]; sb = 0;
                ordy = !(cyc >= 4 && cyc <= 6);
                #1;
                if (cyc >= 4 && cyc <= 6) begin
                    chk($sformatf("stall_in_ready_c%0d", cyc), 32'(ir), 32'd0);
                    chk($sformatf("stall_valid_c%0d", cyc), 32'(ov), 32'd1);
                    if (cyc == 4) held = sm;
                    else chk($sformatf("stall_hold_c%0d", cyc), 32'(sm), 32'(held));
                end
                if (ov && ordy) begin
                    chk($sformatf("bp_res%0d", ngot), 32'(sm), 32'(8'(4 * ngot + (ngot & 1))));
                    ngot++;
                end
                if (iv && ir) nsent++;
                @(posedge clk); #1;
            end
            iv = 0; ordy = 1;
            chk("bp_count", 32'(ngot), 32'd8);
        end

        // Reset mid-flight
        iv = 1; ia = 8'h11; ib = 8'h22; ci = 0; sb = 0;
        tick();
        ia = 8'h33; ib = 8'h44;
        tick();
        iv = 0;
        chk("mid_pre_valid", 32'(ov), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_valid", 32'(ov), 32'd0);
        chk("mid_async_sum", 32'(sm), 32'd0);
        #3 rst_n = 1'b1;
        begin
            int stale = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (ov) stale++;
            end
            chk("mid_no_stale", 32'(stale), 32'd0);
        end

        // Single-stage instance: latency 1
        iv1 = 1; ia1 = 8'hFF; ib1 = 8'h01; ci1 = 0; sb1 = 0;
        tick();
        iv1 = 1; ia1 = 8'h80; ib1 = 8'h01; ci1 = 0; sb1 = 1;
        chk("s1_valid0", 32'(ov1), 32'd1);
        chk("s1_sum0", 32'(sm1), 32'h00);
        chk("s1_cout0", 32'(co1), 32'd1);
        tick();
        iv1 = 0;
        chk("s1_sum1", 32'(sm1), 32'h7F);
        chk("s1_cout1", 32'(co1), 32'd1);
        chk("s1_ovf1", 32'(of1), 32'd1);
        tick();
        chk("s1_empty", 32'(ov1), 32'd0);

        // 32-bit, 4-stage: latency then back-to-back results
        for (int i = 0; i < 4 + 3; i++) begin
            if (i < 4) begin
                iv4 = 1; ia4 = wa[i]; ib4 = wb[i]; ci4 = wc[i]; sb4 = ws[i];
            end else iv4 = 0;
            tick();
            if (i < 3) chk($sformatf("w_lat%0d", i), 32'(ov4), 32'd0);
            else begin
                chk($sformatf("w%0d_valid", i-3), 32'(ov4), 32'd1);
                chk($sformatf("w%0d_sum", i-3), sm4, ws_e[i-3]);
                chk($sformatf("w%0d_cout", i-3), 32'(co4), 32'(wc_e[i-3]));
                chk($sformatf("w%0d_ovf", i-3), 32'(of4), 32'(wo_e[i-3]));
            end
        end
        tick();
        chk("w_empty", 32'(ov4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
